// File: rtl/fx_div_seq.sv
// Iterative signed fixed-point divider: restoring division on magnitudes, one quotient
// bit per cycle, with saturation and flags for overflow and divide-by-zero.
module fx_div_seq #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int QFRAC = WIDTH - QINT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N  = WIDTH + QFRAC;
  localparam int CW = $clog2(N);

  localparam logic [N-1:0]     POS_MAX = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0]     NEG_MAG = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_RES = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_RES = {1'b1, {(WIDTH-1){1'b0}}};

  // ZERO is the single wait cycle a divide-by-zero spends before DONE.
  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  state_t          state, state_nxt;
  logic            sgn, a_neg;
  logic [N-1:0]    num;
  logic [WIDTH-1:0] den;
  logic [WIDTH:0]  rem;
  logic [CW-1:0]   cnt;

  logic            accept, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] rem_sh;
  logic            q_bit;
  logic [WIDTH:0]  rem_nxt;
  logic [N-1:0]    q_fin;
  logic [WIDTH-1:0] sat_res;
  logic            sat_ovf;

  always_comb begin
    accept = valid_in && (state == IDLE);
    last   = (cnt == CW'(N - 1));
    a_mag  = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
    b_mag  = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;
  end

  // num doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom, so after N steps it holds q.
  always_comb begin
    rem_sh  = {rem, num[N-1]};
    q_bit   = (rem_sh >= {2'b00, den});
    rem_nxt = q_bit ? (rem_sh[WIDTH:0] - {1'b0, den}) : rem_sh[WIDTH:0];
    q_fin   = {num[N-2:0], q_bit};
  end

  // A magnitude of exactly 2^(WIDTH-1) with sgn=1 negates to MIN_RES without overflow.
  always_comb begin
    sat_res = '0;
    sat_ovf = 1'b0;
    if (!sgn && (q_fin > POS_MAX)) begin
      sat_res = MAX_RES;
      sat_ovf = 1'b1;
    end else if (sgn && (q_fin > NEG_MAG)) begin
      sat_res = MIN_RES;
      sat_ovf = 1'b1;
    end else if (sgn) begin
      sat_res = (~q_fin[WIDTH-1:0]) + WIDTH'(1);
    end else begin
      sat_res = q_fin[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (b == '0) ? ZERO : CALC;
      CALC: if (last)   state_nxt = DONE;
      ZERO:             state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_in  = (state == IDLE);
    valid_out = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn         <= 1'b0;
      a_neg       <= 1'b0;
      num         <= '0;
      den         <= '0;
      rem         <= '0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sgn   <= a[WIDTH-1] ^ b[WIDTH-1];
          a_neg <= a[WIDTH-1];
          num   <= {a_mag, {QFRAC{1'b0}}};
          den   <= b_mag;
          rem   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          rem <= rem_nxt;
          num <= q_fin;
          cnt <= cnt + CW'(1);
          if (last) begin
            result      <= sat_res;
            overflow    <= sat_ovf;
            div_by_zero <= 1'b0;
          end
        end
        ZERO: begin
          result      <= a_neg ? MIN_RES : MAX_RES;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && valid_in && ready_in)
      assert (!$isunknown({a, b})) else $error("fx_div_seq: X on operands at accept");
  end
`endif

endmodule

// File: tb/tb_fx_div_seq.sv
// Scoreboard bench for fx_div_seq (Q16.16): stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever valid_out is high.
module tb_fx_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready_in, valid_out, div_by_zero, overflow;
  logic [31:0] result;

  always #5 clk = ~clk;

  fx_div_seq #(.WIDTH(32), .QINT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .a(a), .b(b), .valid_out(valid_out), .result(result),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    logic        ovf;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 64'(valid_out), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  function automatic void push_exp(input int idx);
    exp_t e;
    e.res = vecs[idx].res;
    e.dz  = vecs[idx].dz;
    e.ovf = vecs[idx].ovf;
    e.lat = vecs[idx].dz ? 2 : 49;
    e.acc = cyc;
    sb.push_back(e);
  endfunction

  task automatic do_op(input int idx);
    int unsigned t;
    t = 0;
    @(negedge clk);
    a = vecs[idx].a;
    b = vecs[idx].b;
    valid_in = 1'b1;
    while (!ready_in && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready_in) begin
      check("ready_timeout", 64'(ready_in), 64'd1);
    end else begin
      push_exp(idx);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready_in"}, 64'(ready_in), 64'd1);
    check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned accepts, prev_acc, prev_tp, k, idx;
    bit have_prev;

    vecs[0]  = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, 1'b0};
    vecs[2]  = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
    vecs[4]  = '{32'h7FFF0000, 32'h00008000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000000, 32'hFFFB0000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{32'h00078000, 32'hFFFD8000, 32'hFFFD0000, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFFE8000, 32'hFFFF8000, 32'h00030000, 1'b0, 1'b0};
    vecs[10] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(i);
      drain();
    end

    // valid_in held high while operands change every cycle
    accepts   = 0;
    have_prev = 1'b0;
    prev_acc  = 0;
    prev_tp   = 0;
    k         = 0;
    while (accepts < 6 && k < 1000) begin
      @(negedge clk);
      idx = k % NV;
      a = vecs[idx].a;
      b = vecs[idx].b;
      valid_in = 1'b1;
      if (ready_in) begin
        push_exp(int'(idx));
        if (have_prev) check("accept_spacing", 64'(cyc - prev_acc), 64'(prev_tp));
        prev_acc  = cyc;
        prev_tp   = vecs[idx].dz ? 3 : 50;
        have_prev = 1'b1;
        accepts++;
      end
      k++;
    end
    check("held_accepts", 64'(accepts), 64'd6);
    @(negedge clk);
    valid_in = 1'b0;
    drain();

    // reset in the middle of an operation, at cnt=20
    do_op(0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midreset_no_output_result", 64'(result), 64'd0);

    do_op(8);
    drain();
    do_op(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
